// File: rtl/onehot_dec_pkg.sv
// Shared types for the multi-lane one-hot index decoder pipeline.
package onehot_dec_pkg;

  typedef enum logic {
    MODE_DECODE = 1'b0,
    MODE_ACCUM  = 1'b1
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GRP  = 1'b1
  } state_e;

  function automatic int pcnt_width(input int out_width);
    return $clog2(out_width + 1);
  endfunction

endpackage

// File: rtl/onehot_dec_lane.sv
// Combinational per-lane decoder: bit-position index to one-hot mask plus
// an out-of-range flag. Invalid lanes and out-of-range indices give a zero mask.
module onehot_dec_lane #(
  parameter int IDX_WIDTH = 3,
  parameter int OUT_WIDTH = 7
) (
  input  logic [IDX_WIDTH-1:0] idx_i,
  input  logic                 val_i,
  output logic [OUT_WIDTH-1:0] mask_o,
  output logic                 err_o
);

  // One extra bit so OUT_WIDTH == 2**IDX_WIDTH is representable.
  localparam logic [IDX_WIDTH:0]   LIMIT_C = (IDX_WIDTH + 1)'(OUT_WIDTH);
  localparam logic [OUT_WIDTH-1:0] ONE_C   = OUT_WIDTH'(1);

  logic in_range;

  assign in_range = {1'b0, idx_i} < LIMIT_C;
  assign mask_o   = (val_i && in_range) ? (ONE_C << idx_i) : '0;
  assign err_o    = val_i && !in_range;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Multi-lane registered one-hot decoder with DECODE (one mask per beat) and
// ACCUM (OR of indices over a group of beats) modes, valid/ready on both sides.
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int IDX_WIDTH = 3,
  parameter int OUT_WIDTH = 7,
  parameter int NUM_LANE  = 4,
  parameter int MAX_BEATS = 8,
  localparam int PCNT_W   = pcnt_width(OUT_WIDTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode,
  input  logic [NUM_LANE*IDX_WIDTH-1:0] in_idx,
  input  logic [NUM_LANE-1:0]           in_lane_val,
  input  logic                          in_last,
  input  logic                          in_val,
  output logic                          in_rdy,
  output logic [NUM_LANE*OUT_WIDTH-1:0] out_mask,
  output logic [NUM_LANE-1:0]           out_err,
  output logic [NUM_LANE*PCNT_W-1:0]    out_pcnt,
  output logic                          out_trunc,
  output logic                          out_val,
  input  logic                          out_rdy
);

  localparam int MW    = NUM_LANE * OUT_WIDTH;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CLOSE_CNT_C   = CNT_W'(MAX_BEATS - 1);
  localparam bit               SINGLE_BEAT_C = (MAX_BEATS == 1);

  generate
    if (OUT_WIDTH > 2 ** IDX_WIDTH) begin : g_chk_width
      $fatal(1, "OUT_WIDTH must not exceed 2**IDX_WIDTH");
    end
    if (MAX_BEATS < 1) begin : g_chk_beats
      $fatal(1, "MAX_BEATS must be at least 1");
    end
    if (NUM_LANE < 1) begin : g_chk_lanes
      $fatal(1, "NUM_LANE must be at least 1");
    end
  endgenerate

  function automatic logic [PCNT_W-1:0] popcount(input logic [OUT_WIDTH-1:0] v);
    logic [PCNT_W-1:0] c;
    c = '0;
    for (int b = 0; b < OUT_WIDTH; b++) c = c + PCNT_W'(v[b]);
    return c;
  endfunction

  // S_GRP itself carries the latched ACCUM mode; S_IDLE samples mode afresh.
  state_e               state_q, state_d;
  logic [MW-1:0]        acc_q, acc_d;
  logic [NUM_LANE-1:0]  err_acc_q, err_acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]        out_mask_q, out_mask_d;
  logic [NUM_LANE-1:0]  out_err_q, out_err_d;
  logic [NUM_LANE*PCNT_W-1:0] out_pcnt_q, out_pcnt_d;
  logic                 out_trunc_q, out_trunc_d;
  logic                 out_val_q, out_val_d;

  logic [MW-1:0]        dec_mask;
  logic [NUM_LANE-1:0]  dec_err;
  logic [MW-1:0]        emit_mask;
  logic [NUM_LANE-1:0]  emit_err;
  logic [NUM_LANE*PCNT_W-1:0] pcnt_next;
  logic                 emit, emit_trunc, accept;

  assign in_rdy = !out_val_q || out_rdy;
  assign accept = in_val && in_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANE; gi++) begin : g_lane
      onehot_dec_lane #(
        .IDX_WIDTH(IDX_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
      ) u_lane (
        .idx_i (in_idx[gi*IDX_WIDTH +: IDX_WIDTH]),
        .val_i (in_lane_val[gi]),
        .mask_o(dec_mask[gi*OUT_WIDTH +: OUT_WIDTH]),
        .err_o (dec_err[gi])
      );
      assign pcnt_next[gi*PCNT_W +: PCNT_W] = popcount(emit_mask[gi*OUT_WIDTH +: OUT_WIDTH]);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    err_acc_d  = err_acc_q;
    cnt_d      = cnt_q;
    emit       = 1'b0;
    emit_mask  = dec_mask;
    emit_err   = dec_err;
    emit_trunc = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (mode_e'(mode) == MODE_DECODE) begin
            emit = 1'b1;
          end else if (in_last || SINGLE_BEAT_C) begin
            emit       = 1'b1;
            emit_trunc = !in_last;
          end else begin
            state_d   = S_GRP;
            acc_d     = dec_mask;
            err_acc_d = dec_err;
            cnt_d     = CNT_W'(1);
          end
        end
        S_GRP: begin
          emit_mask = acc_q | dec_mask;
          emit_err  = err_acc_q | dec_err;
          if (in_last || cnt_q == CLOSE_CNT_C) begin
            emit       = 1'b1;
            emit_trunc = !in_last;
            state_d    = S_IDLE;
            acc_d      = '0;
            err_acc_d  = '0;
            cnt_d      = '0;
          end else begin
            acc_d     = emit_mask;
            err_acc_d = emit_err;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A new result can only arrive when the slot is free or being drained.
  always_comb begin
    out_val_d   = out_val_q;
    out_mask_d  = out_mask_q;
    out_err_d   = out_err_q;
    out_pcnt_d  = out_pcnt_q;
    out_trunc_d = out_trunc_q;
    if (emit) begin
      out_val_d   = 1'b1;
      out_mask_d  = emit_mask;
      out_err_d   = emit_err;
      out_pcnt_d  = pcnt_next;
      out_trunc_d = emit_trunc;
    end else if (out_rdy) begin
      out_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      err_acc_q   <= '0;
      cnt_q       <= '0;
      out_val_q   <= 1'b0;
      out_mask_q  <= '0;
      out_err_q   <= '0;
      out_pcnt_q  <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      err_acc_q   <= err_acc_d;
      cnt_q       <= cnt_d;
      out_val_q   <= out_val_d;
      out_mask_q  <= out_mask_d;
      out_err_q   <= out_err_d;
      out_pcnt_q  <= out_pcnt_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_val   = out_val_q;
  assign out_mask  = out_mask_q;
  assign out_err   = out_err_q;
  assign out_pcnt  = out_pcnt_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Self-checking bench for onehot_decoder_pipe: directed cases plus random
// traffic compared against a beat-level reference model.
module tb_onehot_decoder_pipe;

  localparam int IW = 3;
  localparam int OW = 7;
  localparam int NL = 4;
  localparam int MB = 8;
  localparam int PW = $clog2(OW + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             mode;
  logic [NL*IW-1:0] in_idx;
  logic [NL-1:0]    in_lane_val;
  logic             in_last, in_val, in_rdy;
  logic [NL*OW-1:0] out_mask;
  logic [NL-1:0]    out_err;
  logic [NL*PW-1:0] out_pcnt;
  logic             out_trunc, out_val, out_rdy;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(
    .IDX_WIDTH(IW), .OUT_WIDTH(OW), .NUM_LANE(NL), .MAX_BEATS(MB)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_idx(in_idx),
    .in_lane_val(in_lane_val), .in_last(in_last), .in_val(in_val),
    .in_rdy(in_rdy), .out_mask(out_mask), .out_err(out_err),
    .out_pcnt(out_pcnt), .out_trunc(out_trunc), .out_val(out_val),
    .out_rdy(out_rdy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  // Reference model: open-group flag, beat count, per-lane OR of bit sets.
  bit               grp_open;
  int               grp_cnt;
  int               acc_m[NL];
  bit               acc_e[NL];
  bit               exp_val;
  logic [NL*OW-1:0] exp_mask;
  logic [NL-1:0]    exp_err;
  logic [NL*PW-1:0] exp_pcnt;
  bit               exp_trunc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input int m);
    int c = 0;
    for (int b = 0; b < OW; b++) c += (m >> b) & 1;
    return c;
  endfunction

  function automatic void emit(input int m[NL], input bit e[NL], input bit tr);
    exp_val = 1'b1;
    for (int l = 0; l < NL; l++) begin
      exp_mask[l*OW +: OW] = OW'(m[l]);
      exp_err[l]           = e[l];
      exp_pcnt[l*PW +: PW] = PW'(popc(m[l]));
    end
    exp_trunc = tr;
  endfunction

  function automatic logic [NL*IW-1:0] pack(input int a, input int b, input int c, input int d);
    return {IW'(d), IW'(c), IW'(b), IW'(a)};
  endfunction

  function automatic void model_clear();
    grp_open = 1'b0;
    grp_cnt  = 0;
    exp_val  = 1'b0;
    for (int l = 0; l < NL; l++) begin
      acc_m[l] = 0;
      acc_e[l] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    check_val("out_val", out_val, exp_val);
    if (exp_val) begin
      check_val("out_mask", out_mask, exp_mask);
      check_val("out_err", out_err, exp_err);
      check_val("out_pcnt", out_pcnt, exp_pcnt);
      check_val("out_trunc", out_trunc, exp_trunc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_val"}, out_val, 0);
    check_val({tag, "_mask"}, out_mask, 0);
    check_val({tag, "_err"}, out_err, 0);
    check_val({tag, "_pcnt"}, out_pcnt, 0);
    check_val({tag, "_trunc"}, out_trunc, 0);
  endtask

  // Called at a negedge: drive one cycle, update the model for the coming edge,
  // then compare the registered outputs at the next negedge.
  task automatic drive(input bit v, input bit md, input logic [NL*IW-1:0] idx,
                       input logic [NL-1:0] lv, input bit last, input bit ordy);
    bit rdy;
    bit acc_ok;
    int dm[NL];
    bit de[NL];
    int mm[NL];
    bit me[NL];
    in_val = v; mode = md; in_idx = idx; in_lane_val = lv; in_last = last; out_rdy = ordy;
    #1;
    rdy = !exp_val || ordy;
    check_val("in_rdy", in_rdy, rdy);
    acc_ok = v && rdy;
    if (exp_val && ordy) begin
      n_out++;
      $display("out %0d: mask=%h err=%b pcnt=%h trunc=%0d", n_out, out_mask, out_err, out_pcnt, out_trunc);
      exp_val = 1'b0;
    end
    if (acc_ok) begin
      for (int l = 0; l < NL; l++) begin
        int ix;
        ix    = int'(idx[l*IW +: IW]);
        dm[l] = (lv[l] && ix < OW) ? (1 << ix) : 0;
        de[l] = lv[l] && (ix >= OW);
      end
      if (!grp_open) begin
        if (!md) emit(dm, de, 1'b0);
        else if (last || MB == 1) emit(dm, de, !last);
        else begin
          grp_open = 1'b1;
          grp_cnt  = 1;
          acc_m    = dm;
          acc_e    = de;
        end
      end else begin
        for (int l = 0; l < NL; l++) begin
          mm[l] = acc_m[l] | dm[l];
          me[l] = acc_e[l] | de[l];
        end
        grp_cnt++;
        if (last) begin
          emit(mm, me, 1'b0);
          grp_open = 1'b0;
        end else if (grp_cnt == MB) begin
          emit(mm, me, 1'b1);
          grp_open = 1'b0;
        end else begin
          acc_m = mm;
          acc_e = me;
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic reset_mid(input string tag);
    in_val = 1'b0;
    out_rdy = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zero(tag);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    int base;
    reset = 1'b1; mode = 1'b0; in_idx = '0; in_lane_val = '0;
    in_last = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_zero("reset");
    check_val("reset_in_rdy", in_rdy, 1);
    reset = 1'b0;
    @(negedge clk);
    check_outputs();

    // DECODE, idx {0,3,6,7} on all lanes
    drive(1'b1, 1'b0, pack(0, 3, 6, 7), 4'hF, 1'b0, 1'b1);
    check_val("t1_mask", out_mask, {7'b0000000, 7'b1000000, 7'b0001000, 7'b0000001});
    check_val("t1_err", out_err, 4'b1000);
    check_val("t1_pcnt", out_pcnt, {3'd0, 3'd1, 3'd1, 3'd1});
    idle(1);

    // DECODE 5 back-to-back beats, 3-cycle output stall after the first
    base = n_out;
    drive(1'b1, 1'b0, pack(1, 2, 3, 4), 4'hF, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1'b0, pack(5, 0, 1, 2), 4'hF, 1'b0, 1'b0);
      check_val("t2_hold", out_mask, {7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010});
    end
    drive(1'b1, 1'b0, pack(5, 0, 1, 2), 4'hF, 1'b0, 1'b1);
    drive(1'b1, 1'b0, pack(6, 6, 6, 6), 4'h5, 1'b0, 1'b1);
    drive(1'b1, 1'b0, pack(0, 7, 0, 7), 4'hF, 1'b0, 1'b1);
    drive(1'b1, 1'b0, pack(4, 4, 3, 3), 4'hE, 1'b0, 1'b1);
    idle(2);
    check_val("t2_count", n_out - base, 5);

    // ACCUM 3 beats lane0 idx 1,1,4
    drive(1'b1, 1'b1, pack(1, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, pack(1, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    check_val("t3_noout", out_val, 0);
    drive(1'b1, 1'b0, pack(4, 0, 0, 0), 4'h1, 1'b1, 1'b1);
    check_val("t3_mask0", out_mask[OW-1:0], 7'b0010010);
    check_val("t3_pcnt0", out_pcnt[PW-1:0], 2);
    check_val("t3_trunc", out_trunc, 0);
    idle(1);

    // ACCUM forced close at MAX_BEATS, then a fresh group
    for (int k = 0; k < MB; k++)
      drive(1'b1, 1'b1, pack((k < 7) ? k : 2, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    check_val("t4_mask0", out_mask[OW-1:0], 7'b1111111);
    check_val("t4_pcnt0", out_pcnt[PW-1:0], 7);
    check_val("t4_trunc", out_trunc, 1);
    drive(1'b1, 1'b1, pack(5, 0, 0, 0), 4'h1, 1'b1, 1'b1);
    check_val("t4_fresh", out_mask[OW-1:0], 7'b0100000);
    check_val("t4_fresh_trunc", out_trunc, 0);

    // ACCUM with an out-of-range index on lane 2 in the first beat only
    drive(1'b1, 1'b1, pack(0, 0, 7, 0), 4'h4, 1'b0, 1'b1);
    drive(1'b1, 1'b1, pack(0, 0, 1, 0), 4'h4, 1'b0, 1'b1);
    drive(1'b1, 1'b1, pack(0, 0, 2, 0), 4'h4, 1'b1, 1'b1);
    check_val("t5_err", out_err, 4'b0100);
    check_val("t5_mask2", out_mask[2*OW +: OW], 7'b0000110);
    idle(1);

    // Reset with an ACCUM group open
    drive(1'b1, 1'b1, pack(1, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, pack(4, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    reset_mid("t6a_rst");
    drive(1'b1, 1'b1, pack(3, 0, 0, 0), 4'h1, 1'b1, 1'b1);
    check_val("t6a_mask0", out_mask[OW-1:0], 7'b0001000);
    idle(1);

    // Reset with an output pending
    drive(1'b1, 1'b0, pack(2, 0, 0, 0), 4'h1, 1'b0, 1'b0);
    reset_mid("t6b_rst");
    drive(1'b1, 1'b0, pack(5, 0, 0, 0), 4'h1, 1'b0, 1'b1);
    check_val("t6b_mask", out_mask, {21'd0, 7'b0100000});
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), (NL*IW)'($urandom),
            NL'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
